// File: rtl/fifo_bus_sel_rr_arbiter.sv
// Per-FIFO write-side round-robin arbiter with a packet-locked grant.
// Accepted beats go into a show-ahead buffer that feeds the downstream port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus_sel    request vector, bit x = fd_x targets this FIFO
//   fd_data    requester x data at [x*DATA_W +: DATA_W]
//   fd_last    requester x last-beat flag
//   fd_ready   accept strobe, only the granted bit can be high
//   out_valid  buffer head valid
//   out_data   buffer head data
//   out_last   buffer head last flag
//   out_ready  downstream pop
//   grant_id   current or most recent granted requester
//   busy       high while a packet grant is held
//   fill       number of buffered entries, 0..DEPTH

module fifo_bus_sel_rr_arbiter #(
    parameter  int PORT_NUM = 4,
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 8,
    localparam int CNT_W    = $clog2(DEPTH) + 1,
    localparam int ID_W     = $clog2(PORT_NUM),
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORT_NUM-1:0]        bus_sel,
    input  logic [PORT_NUM*DATA_W-1:0] fd_data,
    input  logic [PORT_NUM-1:0]        fd_last,
    output logic [PORT_NUM-1:0]        fd_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           fill
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   next_id;
    logic [ID_W-1:0]   cand;
    logic              req_any;

    logic [DATA_W-1:0] data_arr [PORT_NUM];
    logic [DATA_W:0]   mem      [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic              full;
    logic              push;
    logic              pop;
    logic              beat_last;

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_slice
        assign data_arr[g] = fd_data[g*DATA_W +: DATA_W];
    end

    // Walk from the farthest candidate back to rr_ptr+1 so that the
    // nearest requester after rr_ptr is the one left in next_id.
    always_comb begin
        next_id = rr_ptr;
        req_any = 1'b0;
        cand    = '0;
        for (int k = PORT_NUM; k >= 1; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % PORT_NUM);
            if (bus_sel[cand]) begin
                next_id = cand;
                req_any = 1'b1;
            end
        end
    end

    assign full      = (fill == CNT_W'(DEPTH));
    assign busy      = (state == BUSY);
    assign beat_last = fd_last[grant_id];

    // Ready follows the current fill only, so a full buffer refuses a
    // beat even when a pop happens in the same cycle.
    always_comb begin
        fd_ready = '0;
        if (state == BUSY) begin
            fd_ready[grant_id] = ~full;
        end
    end

    assign push = (state == BUSY) & bus_sel[grant_id] & ~full;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= ID_W'(PORT_NUM - 1);
            grant_id <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_any) begin
                        grant_id <= next_id;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (push && beat_last) begin
                        rr_ptr <= grant_id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed when fill != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {beat_last, data_arr[grant_id]};
        end
    end

    assign out_valid = (fill != '0);
    assign out_data  = out_valid ? mem[rd_ptr][DATA_W-1:0] : '0;
    assign out_last  = out_valid ? mem[rd_ptr][DATA_W] : 1'b0;

endmodule

// File: tb/tb_fifo_bus_sel_rr_arbiter.sv
// Bench for fifo_bus_sel_rr_arbiter: packet drivers feed a scoreboard
// queue, a monitor pops and compares every beat leaving the buffer.

module tb_fifo_bus_sel_rr_arbiter;

    localparam int PORT_NUM = 4;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 4;
    localparam int ID_W     = 2;

    logic                       clk;
    logic                       rst_n;
    logic [PORT_NUM-1:0]        bus_sel;
    logic [PORT_NUM*DATA_W-1:0] fd_data;
    logic [PORT_NUM-1:0]        fd_last;
    logic [PORT_NUM-1:0]        fd_ready;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_last;
    logic                       out_ready;
    logic [ID_W-1:0]            grant_id;
    logic                       busy;
    logic [CNT_W-1:0]           fill;

    fifo_bus_sel_rr_arbiter #(
        .PORT_NUM(PORT_NUM),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_sel  (bus_sel),
        .fd_data  (fd_data),
        .fd_last  (fd_last),
        .fd_ready (fd_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .grant_id (grant_id),
        .busy     (busy),
        .fill     (fill)
    );

    int              checks   = 0;
    int              failures = 0;
    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] mon_exp;
    bit              drv_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(fd_ready) > 1 || (fd_ready != '0 && !busy)) begin
                failures++;
                $display("FAIL ready_onehot got fd_ready=%b busy=%b expected onehot0 under busy",
                         fd_ready, busy);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_beat got=%h last=%b expected=none", out_data, out_last);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({out_last, out_data} !== mon_exp) begin
                        failures++;
                        $display("FAIL out_beat got=%h last=%b expected=%h last=%b",
                                 out_data, out_last, mon_exp[DATA_W-1:0], mon_exp[DATA_W]);
                    end
                end
            end
        end
    end

    task automatic send_pkt(input int p, input int n, input logic [31:0] base,
                            input int gap_at, input int gap_len);
        int waited;
        for (int b = 0; b < n; b++) begin
            bus_sel[p] = 1'b1;
            fd_data[p*DATA_W +: DATA_W] = base + 32'(b);
            fd_last[p] = (b == n - 1);
            waited = 0;
            @(negedge clk);
            while (!fd_ready[p] && waited < 300) begin
                waited++;
                @(negedge clk);
            end
            if (!fd_ready[p]) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout port=%0d beat=%0d got=no_ready expected=ready", p, b);
                bus_sel[p] = 1'b0;
                fd_last[p] = 1'b0;
                return;
            end
            exp_q.push_back({fd_last[p], fd_data[p*DATA_W +: DATA_W]});
            @(posedge clk);
            #1;
            if (b == gap_at) begin
                bus_sel[p] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        bus_sel[p] = 1'b0;
        fd_last[p] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(posedge clk);
            i++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || fill !== '0) begin
            failures++;
            $display("FAIL drain_%s got left=%0d fill=%0d valid=%b expected 0 0 0",
                     name, exp_q.size(), fill, out_valid);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bus_sel   = '0;
        fd_data   = '0;
        fd_last   = '0;
        out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus_sel   = '0;
        fd_data   = '0;
        fd_last   = '0;
        out_ready = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || fill !== '0 || fd_ready !== '0) begin
            failures++;
            $display("FAIL reset_buf got valid=%b fill=%0d ready=%b expected 0 0 0",
                     out_valid, fill, fd_ready);
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== '0) begin
            failures++;
            $display("FAIL reset_fsm got busy=%b grant=%0d expected 0 0", busy, grant_id);
        end
        checks++;
        if (out_data !== '0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got data=%h last=%b expected 0 0", out_data, out_last);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        bus_sel   = 4'b0100;
        fd_data[2*DATA_W +: DATA_W] = 32'hDEAD_0000;
        fd_last   = '0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (fill !== 4'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got fill=%0d busy=%b expected 3 1", fill, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fill !== '0 || fd_ready !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_async got valid=%b fill=%0d ready=%b busy=%b expected 0 0 0 0",
                     out_valid, fill, fd_ready, busy);
        end
        bus_sel = '0;
        do_reset();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        fork
            send_pkt(2, 3, 32'hA0, -1, 0);
            begin
                @(posedge clk);
                #1;
                checks++;
                if (grant_id !== 2'd2 || busy !== 1'b1 || fd_ready !== 4'b0100) begin
                    failures++;
                    $display("FAIL single_grant got grant=%0d busy=%b ready=%b expected 2 1 0100",
                             grant_id, busy, fd_ready);
                end
                @(posedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'hA0) begin
                    failures++;
                    $display("FAIL single_latency got valid=%b data=%h expected 1 a0",
                             out_valid, out_data);
                end
            end
        join
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_fall got=%b expected=0", busy);
        end
        wait_drain("single");
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        out_ready = 1'b1;
        fork
            begin
                send_pkt(0, 1, 32'h100, -1, 0);
                send_pkt(0, 1, 32'h101, -1, 0);
            end
            send_pkt(1, 1, 32'h110, -1, 0);
            send_pkt(2, 1, 32'h120, -1, 0);
            send_pkt(3, 1, 32'h130, -1, 0);
            begin
                logic pb;
                int   gap;
                pb = busy;
                for (int g = 0; g < 5; g++) begin
                    gap = 0;
                    do begin
                        pb = busy;
                        @(posedge clk);
                        #1;
                        gap++;
                    end while (!(busy && !pb) && gap < 50);
                    checks++;
                    if (!(busy && !pb) || grant_id !== ID_W'(exp_order[g])) begin
                        failures++;
                        $display("FAIL rr_order idx=%0d got=%0d expected=%0d", g, grant_id,
                                 exp_order[g]);
                    end
                    if (g > 0) begin
                        checks++;
                        if (gap != 2) begin
                            failures++;
                            $display("FAIL rr_bubble idx=%0d got=%0d expected=2", g, gap);
                        end
                    end
                end
            end
        join
        wait_drain("rr");
    endtask

    task automatic test_full_and_simul();
        int i;
        out_ready = 1'b0;
        drv_done  = 1'b0;
        fork
            begin
                send_pkt(1, 10, 32'h200, -1, 0);
                drv_done = 1'b1;
            end
        join_none
        i = 0;
        while (fill !== 4'd8 && i < 60) begin
            @(posedge clk);
            #1;
            i++;
        end
        checks++;
        if (fill !== 4'd8 || fd_ready !== 4'b0000 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_reach got fill=%0d ready=%b valid=%b expected 8 0000 1",
                     fill, fd_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fill !== 4'd8 || busy !== 1'b1) begin
            failures++;
            $display("FAIL full_stall got fill=%0d busy=%b expected 8 1", fill, busy);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (fill !== 4'd7 || fd_ready !== 4'b0010) begin
            failures++;
            $display("FAIL simul_pop_only got fill=%0d ready=%b expected 7 0010", fill, fd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fill !== 4'd7) begin
            failures++;
            $display("FAIL simul_push_pop got fill=%0d expected 7", fill);
        end
        i = 0;
        while (!drv_done && i < 100) begin
            @(posedge clk);
            i++;
        end
        checks++;
        if (!drv_done) begin
            failures++;
            $display("FAIL full_driver got=stuck expected=done");
        end
        wait_drain("full");
    endtask

    task automatic test_lock();
        out_ready = 1'b1;
        fork
            send_pkt(0, 4, 32'h300, 1, 5);
            begin
                @(posedge clk);
                #1;
                send_pkt(3, 2, 32'h400, -1, 0);
            end
            begin
                logic pb;
                int   i;
                @(posedge clk);
                #1;
                checks++;
                if (grant_id !== 2'd0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_first got grant=%0d busy=%b expected 0 1", grant_id, busy);
                end
                for (int c = 0; c < 6; c++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (grant_id !== 2'd0 || busy !== 1'b1 || fd_ready !== 4'b0001) begin
                        failures++;
                        $display("FAIL lock_hold cyc=%0d got grant=%0d busy=%b ready=%b expected 0 1 0001",
                                 c, grant_id, busy, fd_ready);
                    end
                end
                i  = 0;
                pb = busy;
                do begin
                    pb = busy;
                    @(posedge clk);
                    #1;
                    i++;
                end while (!(busy && !pb) && i < 50);
                checks++;
                if (!(busy && !pb) || grant_id !== 2'd3) begin
                    failures++;
                    $display("FAIL lock_next got grant=%0d busy=%b expected 3 1", grant_id, busy);
                end
            end
        join
        wait_drain("lock");
    endtask

    initial begin
        drv_done = 1'b0;
        test_reset();
        test_reset_mid();
        test_single();
        test_round_robin();
        test_full_and_simul();
        test_lock();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
